// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared type definitions for the pipelined Wishbone RAM:
//            controller FSM state encoding and bus response-type encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Controller states: INIT sweeps the array to zero, READY serves the bus.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Response carried through the delay line for each accepted request.
    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_ACK  = 2'b01,
        RSP_ERR  = 2'b10
    } rsp_e;

endpackage
`default_nettype wire

// File: rtl/wb_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_resp_pipe
// Purpose  : READ_LAT-stage response delay line. Carries a valid bit, an
//            error flag and read data from request acceptance to the bus
//            response cycle. squash_i kills every in-flight entry, including
//            the one being presented this cycle.
// Ports    : clk_i    - clock (rising edge)
//            rst_ni   - asynchronous active-low reset
//            squash_i - drop all in-flight responses (bus cycle ended)
//            rsp_i    - response type entering the line (NONE when idle)
//            dat_i    - read data entering the line
//            rsp_o    - response type leaving the line
//            dat_o    - read data, zero unless rsp_o is ACK
// Revision : 1.0 - initial release
// ============================================================================
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int D_WIDTH  = 32,
    parameter int READ_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               squash_i,
    input  rsp_e               rsp_i,
    input  logic [D_WIDTH-1:0] dat_i,
    output rsp_e               rsp_o,
    output logic [D_WIDTH-1:0] dat_o
);

    logic [READ_LAT-1:0] valid_q;
    logic [READ_LAT-1:0] err_q;
    logic [D_WIDTH-1:0]  data_q [READ_LAT];
    logic                w_out_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= (rsp_i != RSP_NONE) && !squash_i;
            err_q[0]   <= (rsp_i == RSP_ERR);
            // Only read acks carry data; writes and errors travel as zero.
            data_q[0]  <= (rsp_i == RSP_ACK) ? dat_i : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_q[i] <= valid_q[i-1] && !squash_i;
                err_q[i]   <= err_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // Gating with squash_i also suppresses a response due in the very
    // cycle the master drops its bus cycle.
    assign w_out_valid = valid_q[READ_LAT-1] && !squash_i;

    always_comb begin
        rsp_o = RSP_NONE;
        dat_o = '0;
        if (w_out_valid) begin
            if (err_q[READ_LAT-1]) begin
                rsp_o = RSP_ERR;
            end else begin
                rsp_o = RSP_ACK;
                dat_o = data_q[READ_LAT-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_pipe
// Purpose  : Wishbone B4 pipelined single-port RAM with per-lane byte
//            selects, fixed READ_LAT response latency, error response for
//            addresses beyond DEPTH and an optional zeroing sweep after reset.
// Ports    : clk_i   - clock (rising edge)
//            rst_ni  - asynchronous active-low reset
//            cyc_i   - bus cycle; low squashes in-flight responses
//            stb_i   - request strobe
//            we_i    - write enable
//            adr_i   - word address
//            dat_i   - write data
//            sel_i   - lane enables for writes
//            dat_o   - read data (zero outside read acks)
//            ack_o   - normal completion
//            err_o   - error completion (address out of range)
//            stall_o - request not accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module wb_ram_pipe
    import wb_pkg::*;
#(
    parameter int D_WIDTH     = 32,
    parameter int A_WIDTH     = 10,
    parameter int GRANULARITY = 8,
    parameter int DEPTH       = 1 << A_WIDTH,
    parameter int READ_LAT    = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cyc_i,
    input  logic                           stb_i,
    input  logic                           we_i,
    input  logic [A_WIDTH-1:0]             adr_i,
    input  logic [D_WIDTH-1:0]             dat_i,
    input  logic [D_WIDTH/GRANULARITY-1:0] sel_i,
    output logic [D_WIDTH-1:0]             dat_o,
    output logic                           ack_o,
    output logic                           err_o,
    output logic                           stall_o
);

    localparam int                 SEL_W       = D_WIDTH / GRANULARITY;
    localparam logic [A_WIDTH-1:0] LAST_WORD   = A_WIDTH'(DEPTH - 1);
    localparam logic [A_WIDTH:0]   DEPTH_W     = (A_WIDTH + 1)'(DEPTH);
    localparam state_e             RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    // Elaboration-time parameter checks.
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_chk_read_lat
        $error("wb_ram_pipe: READ_LAT must be 1 or 2");
    end
    if ((DEPTH < 1) || (DEPTH > (1 << A_WIDTH))) begin : g_chk_depth
        $error("wb_ram_pipe: DEPTH must be in 1..2**A_WIDTH");
    end
    if ((SEL_W * GRANULARITY) != D_WIDTH) begin : g_chk_lanes
        $error("wb_ram_pipe: D_WIDTH must be a multiple of GRANULARITY");
    end

    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [D_WIDTH-1:0]   mem_q [DEPTH];

    logic                 w_accept;
    logic                 w_in_range;
    logic [A_WIDTH-1:0]   w_rd_idx;
    logic [D_WIDTH-1:0]   w_rd_data;
    rsp_e                 w_rsp_in;
    rsp_e                 w_rsp_out;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET_STATE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stall_o    = 1'b0;
        case (state_q)
            ST_INIT: begin
                stall_o = 1'b1;
                if (init_cnt_q == LAST_WORD) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + A_WIDTH'(1);
                end
            end
            ST_READY: begin
                stall_o = 1'b0;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------- request
    assign w_accept   = cyc_i && stb_i && !stall_o;
    // One extra bit so DEPTH == 2**A_WIDTH compares correctly.
    assign w_in_range = ({1'b0, adr_i} < DEPTH_W);

    always_comb begin
        w_rsp_in = RSP_NONE;
        if (w_accept) begin
            w_rsp_in = w_in_range ? RSP_ACK : RSP_ERR;
        end
    end

    // -------------------------------------------------------------- memory
    // No reset on the array: only the INIT sweep clears it.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem_q[init_cnt_q] <= '0;
        end else if (w_accept && we_i && w_in_range) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (sel_i[k]) begin
                    mem_q[adr_i][k*GRANULARITY +: GRANULARITY] <= dat_i[k*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    // Asynchronous array read captured by the first delay-line stage, so a
    // read right after a write to the same word sees the new contents.
    assign w_rd_idx  = w_in_range ? adr_i : '0;
    assign w_rd_data = we_i ? '0 : mem_q[w_rd_idx];

    // ------------------------------------------------------- response line
    wb_resp_pipe #(
        .D_WIDTH  (D_WIDTH),
        .READ_LAT (READ_LAT)
    ) u_resp_pipe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .squash_i (!cyc_i),
        .rsp_i    (w_rsp_in),
        .dat_i    (w_rd_data),
        .rsp_o    (w_rsp_out),
        .dat_o    (dat_o)
    );

    assign ack_o = (w_rsp_out == RSP_ACK);
    assign err_o = (w_rsp_out == RSP_ERR);

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_pipe
// Purpose  : Self-checking bench for wb_ram_pipe. Two instances share one
//            stimulus stream: A (DEPTH=12, READ_LAT=2) and B (DEPTH=16,
//            READ_LAT=1). Expected responses are queued at request time from
//            a reference memory model and compared as the DUTs respond.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ram_pipe;

    localparam int DW      = 32;
    localparam int AW      = 4;
    localparam int SW      = 4;
    localparam int DEPTH_A = 12;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 16;
    localparam int LAT_B   = 1;

    logic          clk;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;

    logic [DW-1:0] dat_a, dat_b;
    logic          ack_a, err_a, stall_a;
    logic          ack_b, err_b, stall_b;

    int n_tests   = 0;
    int n_fail    = 0;
    int cycle_cnt = 0;

    typedef struct {
        int            due;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] mdl_a [DEPTH_A];
    logic [DW-1:0] mdl_b [DEPTH_B];

    wb_ram_pipe #(
        .D_WIDTH(DW), .A_WIDTH(AW), .GRANULARITY(8),
        .DEPTH(DEPTH_A), .READ_LAT(LAT_A), .INIT_ZERO(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel),
        .dat_o(dat_a), .ack_o(ack_a), .err_o(err_a), .stall_o(stall_a)
    );

    wb_ram_pipe #(
        .D_WIDTH(DW), .A_WIDTH(AW), .GRANULARITY(8),
        .DEPTH(DEPTH_B), .READ_LAT(LAT_B), .INIT_ZERO(1)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel),
        .dat_o(dat_b), .ack_o(ack_b), .err_o(err_b), .stall_o(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ack_a || err_a) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_rsp: got ack=%0b err=%0b dat=%h cycle=%0d, expected no response",
                         ack_a, err_a, dat_a, cycle_cnt);
            end else begin
                e = q_a.pop_front();
                if (cycle_cnt !== e.due || ack_a !== !e.err || err_a !== e.err || dat_a !== e.data) begin
                    n_fail++;
                    $display("FAIL a_rsp: got ack=%0b err=%0b dat=%h cycle=%0d, expected ack=%0b err=%0b dat=%h cycle=%0d",
                             ack_a, err_a, dat_a, cycle_cnt, !e.err, e.err, e.data, e.due);
                end
            end
        end else begin
            n_tests++;
            if (dat_a !== '0) begin
                n_fail++;
                $display("FAIL a_dat_idle: got dat=%h, expected 0", dat_a);
            end
            if (q_a.size() != 0 && q_a[0].due <= cycle_cnt) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_missing_rsp: got no response at cycle %0d, expected one due at cycle %0d",
                         cycle_cnt, q_a[0].due);
                void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ack_b || err_b) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_rsp: got ack=%0b err=%0b dat=%h cycle=%0d, expected no response",
                         ack_b, err_b, dat_b, cycle_cnt);
            end else begin
                e = q_b.pop_front();
                if (cycle_cnt !== e.due || ack_b !== !e.err || err_b !== e.err || dat_b !== e.data) begin
                    n_fail++;
                    $display("FAIL b_rsp: got ack=%0b err=%0b dat=%h cycle=%0d, expected ack=%0b err=%0b dat=%h cycle=%0d",
                             ack_b, err_b, dat_b, cycle_cnt, !e.err, e.err, e.data, e.due);
                end
            end
        end else begin
            n_tests++;
            if (dat_b !== '0) begin
                n_fail++;
                $display("FAIL b_dat_idle: got dat=%h, expected 0", dat_b);
            end
            if (q_b.size() != 0 && q_b[0].due <= cycle_cnt) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_missing_rsp: got no response at cycle %0d, expected one due at cycle %0d",
                         cycle_cnt, q_b[0].due);
                void'(q_b.pop_front());
            end
        end
    end

    // ------------------------------------------------------------- drivers
    // Called just after a rising edge; returns just after the next one.
    task automatic drive_req(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        exp_t e;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        if (!stall_a) begin
            e.due = cycle_cnt + LAT_A;
            e.err = 1'b0;
            e.data = '0;
            if (int'(a) >= DEPTH_A) begin
                e.err = 1'b1;
            end else if (w) begin
                for (int k = 0; k < SW; k++)
                    if (s[k]) mdl_a[a][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                e.data = mdl_a[a];
            end
            q_a.push_back(e);
        end
        if (!stall_b) begin
            e.due = cycle_cnt + LAT_B;
            e.err = 1'b0;
            e.data = '0;
            if (int'(a) >= DEPTH_B) begin
                e.err = 1'b1;
            end else if (w) begin
                for (int k = 0; k < SW; k++)
                    if (s[k]) mdl_b[a][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                e.data = mdl_b[a];
            end
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        cyc = 1'b1; stb = 1'b0; we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Dropping cyc squashes everything in flight on both instances.
    task automatic drop_cyc();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        q_a.delete();
        q_b.delete();
        @(posedge clk); #1;
        cyc = 1'b1;
    endtask

    task automatic count_init(output int na, output int nb);
        na = 0; nb = 0;
        repeat (30) begin
            @(negedge clk);
            if (stall_a) na++;
            if (stall_b) nb++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH_A; i++) mdl_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) mdl_b[i] = '0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ack_a, err_a, ack_b, err_b} !== 4'b0000 || dat_a !== '0 || dat_b !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack/err a=%0b%0b b=%0b%0b dat a=%h b=%h, expected all 0",
                     ack_a, err_a, ack_b, err_b, dat_a, dat_b);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (stall_a !== 1'b1 || stall_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall: got a=%0b b=%0b, expected 1 1", stall_a, stall_b);
        end
    endtask

    task automatic test_init_sweep();
        int na, nb;
        rst_n = 1'b1;
        count_init(na, nb);
        n_tests++;
        if (na != DEPTH_A || nb != DEPTH_B) begin
            n_fail++;
            $display("FAIL init_len: got stall cycles a=%0d b=%0d, expected %0d %0d", na, nb, DEPTH_A, DEPTH_B);
        end
        n_tests++;
        if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_stall: got a=%0b b=%0b, expected 0 0", stall_a, stall_b);
        end
    endtask

    task automatic test_drain(input string tag);
        idle(4);
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got pending a=%0d b=%0d, expected 0 0", tag, q_a.size(), q_b.size());
        end
    endtask

    task automatic test_init_zero();
        for (int i = 0; i < 16; i++) drive_req(1'b0, AW'(i), '0, '1);
        test_drain("init_zero");
    endtask

    task automatic test_byte_lanes();
        drive_req(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111);
        drive_req(1'b1, 4'd3, 32'h00000011, 4'b0001);
        drive_req(1'b0, 4'd3, '0, 4'b1111);
        drive_req(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);
        drive_req(1'b0, 4'd3, '0, 4'b0000);
        drive_req(1'b1, 4'd5, 32'h11223344, 4'b1111);
        drive_req(1'b1, 4'd5, 32'hAABBCCDD, 4'b1010);
        drive_req(1'b0, 4'd5, '0, 4'b0001);
        test_drain("byte_lanes");
    endtask

    task automatic test_out_of_range();
        drive_req(1'b0, 4'd13, '0, 4'b1111);
        drive_req(1'b1, 4'd13, 32'hCAFEF00D, 4'b1111);
        drive_req(1'b0, 4'd12, '0, 4'b1111);
        for (int i = 0; i < DEPTH_A; i++) drive_req(1'b0, AW'(i), '0, 4'b1111);
        drive_req(1'b0, 4'd13, '0, 4'b1111);
        drive_req(1'b0, 4'd15, '0, 4'b1111);
        test_drain("out_of_range");
    endtask

    task automatic test_squash();
        drive_req(1'b0, 4'd3, '0, 4'b1111);
        drive_req(1'b0, 4'd5, '0, 4'b1111);
        drop_cyc();
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (ack_a || err_a || ack_b || err_b) begin
                n_fail++;
                $display("FAIL squash_rsp: got ack/err a=%0b%0b b=%0b%0b, expected 0000",
                         ack_a, err_a, ack_b, err_b);
            end
        end
        @(posedge clk); #1;
        drive_req(1'b1, 4'd7, 32'h5A5A5A5A, 4'b1111);
        drop_cyc();
        idle(3);
        drive_req(1'b0, 4'd7, '0, 4'b1111);
        test_drain("squash");
    endtask

    task automatic test_reset_mid_txn();
        drive_req(1'b0, 4'd3, '0, 4'b1111);
        drive_req(1'b0, 4'd5, '0, 4'b1111);
        n_tests++;
        if (ack_a !== 1'b1 || ack_b !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_ack: got a=%0b b=%0b, expected 1 1", ack_a, ack_b);
        end
        q_a.delete();
        q_b.delete();
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ack_a, err_a, ack_b, err_b} !== 4'b0000 || dat_a !== '0 || dat_b !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_txn: got ack/err a=%0b%0b b=%0b%0b dat a=%h b=%h, expected all 0",
                     ack_a, err_a, ack_b, err_b, dat_a, dat_b);
        end
        n_tests++;
        if (stall_a !== 1'b1 || stall_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_txn_stall: got a=%0b b=%0b, expected 1 1", stall_a, stall_b);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_init();
        int na, nb;
        // Requests held during INIT must never be accepted.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (stall_a !== 1'b1 || stall_b !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_init_stall: got a=%0b b=%0b, expected 1 1", stall_a, stall_b);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        rst_n = 1'b1;
        count_init(na, nb);
        n_tests++;
        if (na != DEPTH_A || nb != DEPTH_B) begin
            n_fail++;
            $display("FAIL reinit_len: got stall cycles a=%0d b=%0d, expected %0d %0d", na, nb, DEPTH_A, DEPTH_B);
        end
        // Words written before the reset must be cleared by the restarted sweep.
        drive_req(1'b0, 4'd3, '0, 4'b1111);
        drive_req(1'b0, 4'd5, '0, 4'b1111);
        drive_req(1'b0, 4'd7, '0, 4'b1111);
        drive_req(1'b0, 4'd13, '0, 4'b1111);
        test_drain("reinit");
    endtask

    initial begin
        rst_n = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat = '0; sel = '0;
        for (int i = 0; i < DEPTH_A; i++) mdl_a[i] = '0;
        for (int i = 0; i < DEPTH_B; i++) mdl_b[i] = '0;

        test_reset();
        test_init_sweep();
        test_init_zero();
        test_byte_lanes();
        test_out_of_range();
        test_squash();
        test_reset_mid_txn();
        test_reset_mid_init();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
